// File: rtl/alu_pkg.sv
// Shared opcodes, flag bit positions and flag type for the alu_pipe datapath.
package alu_pkg;

  localparam logic [4:0] OP_AND  = 5'b0_0000;
  localparam logic [4:0] OP_OR   = 5'b0_0001;
  localparam logic [4:0] OP_XOR  = 5'b0_0010;
  localparam logic [4:0] OP_NOT  = 5'b0_0011;
  localparam logic [4:0] OP_NAND = 5'b0_0100;
  localparam logic [4:0] OP_ADD  = 5'b0_0101;
  localparam logic [4:0] OP_SUB  = 5'b0_0110;
  localparam logic [4:0] OP_SWAP = 5'b0_0111;
  localparam logic [4:0] OP_SHL  = 5'b0_1000;
  localparam logic [4:0] OP_ROL  = 5'b0_1001;
  localparam logic [4:0] OP_SHR  = 5'b0_1010;
  localparam logic [4:0] OP_ROR  = 5'b0_1011;
  localparam logic [4:0] OP_INC  = 5'b0_1100;
  localparam logic [4:0] OP_DEC  = 5'b0_1101;
  localparam logic [4:0] OP_CLR  = 5'b0_1110;
  localparam logic [4:0] OP_SET  = 5'b0_1111;
  localparam logic [4:0] OP_MUL  = 5'b1_0000;
  localparam logic [4:0] OP_MFHI = 5'b1_0001;
  localparam logic [4:0] OP_ADC  = 5'b1_0101;
  localparam logic [4:0] OP_SBB  = 5'b1_0110;

  localparam int unsigned FLAG_C = 0;
  localparam int unsigned FLAG_Z = 1;
  localparam int unsigned FLAG_N = 2;
  localparam int unsigned FLAG_V = 3;

  typedef logic [3:0] flags_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle, the last one
// folded in combinationally so the product is ready WIDTH cycles after start.
module alu_mul_iter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH);

  logic             running;
  logic [CW-1:0]    cnt;
  logic [PW-1:0]    acc;
  logic [PW-1:0]    mcand;
  logic [WIDTH-1:0] mplier;
  logic [PW-1:0]    addend;

  assign addend  = mplier[0] ? mcand : '0;
  assign product = acc + addend;
  assign done    = running && (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      running <= 1'b0;
      cnt     <= '0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
    end else if (start) begin
      running <= 1'b1;
      cnt     <= '0;
      acc     <= '0;
      mcand   <= PW'(a);
      mplier  <= b;
    end else if (running) begin
      acc     <= product;
      mcand   <= mcand << 1;
      mplier  <= mplier >> 1;
      cnt     <= cnt + CW'(1);
      if (done) running <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Registered WIDTH-bit ALU with valid/ready handshake and persistent C/Z/N/V flags.
// Define ALU_MUL_EN to add the iterative multiplier (MUL) and HI register (MFHI).
module alu_pipe
  import alu_pkg::*;
#(
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned NW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [NW-1:0]    n,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic [3:0]       flags,
  output logic             err
);

  localparam int unsigned MSB = WIDTH - 1;
  localparam int unsigned W1  = WIDTH + 1;

  flags_t           flag_q;
  flags_t           alu_flags;
  logic             busy;
  logic             accept;
  logic             load_alu;
  logic [WIDTH-1:0] res;
  logic             cf;
  logic             vf;
  logic             legal;
  logic             keep_flags;
  logic             is_mul;
  logic [WIDTH:0]   ext_a;
  logic [WIDTH:0]   ext_b;
  logic [WIDTH:0]   wide;
  logic [WIDTH-1:0] bit_mask;

`ifdef ALU_MUL_EN
  logic               mul_done;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH-1:0]   hi_q;
  flags_t             mul_flags;
`endif

  assign ext_a    = {1'b0, a};
  assign ext_b    = {1'b0, b};
  assign bit_mask = WIDTH'(1) << n;
  assign in_ready = !rst && !busy && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign load_alu = accept && !is_mul;
  assign flags    = flag_q;

  // Single-cycle operation mux; carry-in for ADC/SBB/rotates is the stored C.
  always_comb begin
    res        = '0;
    cf         = 1'b0;
    vf         = 1'b0;
    legal      = 1'b1;
    keep_flags = 1'b0;
    is_mul     = 1'b0;
    wide       = '0;
    alu_flags  = '0;
    case (op)
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_NOT:  res = ~a;
      OP_NAND: res = ~(a & b);
      OP_ADD, OP_ADC: begin
        wide = ext_a + ext_b + W1'(op[4] & flag_q[FLAG_C]);
        res  = wide[MSB:0];
        cf   = wide[WIDTH];
        vf   = (a[MSB] == b[MSB]) && (res[MSB] != a[MSB]);
      end
      OP_SUB, OP_SBB: begin
        wide = ext_a - ext_b - W1'(op[4] & flag_q[FLAG_C]);
        res  = wide[MSB:0];
        cf   = wide[WIDTH];
        vf   = (a[MSB] != b[MSB]) && (res[MSB] != a[MSB]);
      end
      OP_SWAP: res = {a[WIDTH/2-1:0], a[MSB:WIDTH/2]};
      OP_SHL: begin
        res = {a[MSB-1:0], 1'b0};
        cf  = a[MSB];
      end
      OP_ROL: begin
        res = {a[MSB-1:0], flag_q[FLAG_C]};
        cf  = a[MSB];
      end
      OP_SHR: begin
        res = {1'b0, a[MSB:1]};
        cf  = a[0];
      end
      OP_ROR: begin
        res = {flag_q[FLAG_C], a[MSB:1]};
        cf  = a[0];
      end
      OP_INC: begin
        wide = ext_b + W1'(1);
        res  = wide[MSB:0];
        cf   = wide[WIDTH];
      end
      OP_DEC: begin
        wide = ext_b - W1'(1);
        res  = wide[MSB:0];
        cf   = wide[WIDTH];
      end
      OP_CLR: res = b & ~bit_mask;
      OP_SET: res = b | bit_mask;
`ifdef ALU_MUL_EN
      OP_MUL:  is_mul = 1'b1;
      OP_MFHI: begin
        res        = hi_q;
        keep_flags = 1'b1;
      end
`endif
      default: legal = 1'b0;
    endcase
    alu_flags[FLAG_C] = cf;
    alu_flags[FLAG_Z] = (res == '0);
    alu_flags[FLAG_N] = res[MSB];
    alu_flags[FLAG_V] = vf;
  end

`ifdef ALU_MUL_EN
  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (accept && is_mul),
    .a       (a),
    .b       (b),
    .done    (mul_done),
    .product (product)
  );

  always_comb begin
    mul_flags         = '0;
    mul_flags[FLAG_C] = |product[2*WIDTH-1:WIDTH];
    mul_flags[FLAG_Z] = (product == '0);
    mul_flags[FLAG_N] = product[MSB];
  end

  // Busy spans the multiply; HI is only captured when a product completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      hi_q <= '0;
    end else begin
      if (accept && is_mul) busy <= 1'b1;
      else if (mul_done)    busy <= 1'b0;
      if (mul_done) hi_q <= product[2*WIDTH-1:WIDTH];
    end
  end
`else
  assign busy = 1'b0;
`endif

  // Output register and flags register load together; illegal ops and MFHI keep flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      y         <= '0;
      err       <= 1'b0;
      flag_q    <= '0;
    end else if (load_alu) begin
      out_valid <= 1'b1;
      y         <= res;
      err       <= !legal;
      if (legal && !keep_flags) flag_q <= alu_flags;
    end
`ifdef ALU_MUL_EN
    else if (mul_done) begin
      out_valid <= 1'b1;
      y         <= product[MSB:0];
      err       <= 1'b0;
      flag_q    <= mul_flags;
    end
`endif
    else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: directed cases plus random ops against an arithmetic model.
module tb_alu_pipe;
  import alu_pkg::*;

  localparam int unsigned W  = 8;
  localparam int unsigned NW = 3;
  localparam longint FULL = longint'(1) << W;
  localparam longint HALF = longint'(1) << (W - 1);
  localparam longint QW   = longint'(1) << (W / 2);

  typedef struct {
    logic [W-1:0] y;
    logic [3:0]   f;
    logic         e;
    int           acc;
    int           lat;
    logic [4:0]   op;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [4:0]    op;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic [NW-1:0] n;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  y;
  logic [3:0]    flags;
  logic          err;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  bit   stall = 1'b0;
  bit   rand_ready = 1'b0;
  exp_t sbq[$];
  logic [3:0] mflags;
`ifdef ALU_MUL_EN
  logic [W-1:0] mhi;
`endif

  alu_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .n         (n),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .flags     (flags),
    .err       (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic longint sgn(input longint x);
    return (x >= HALF) ? x - FULL : x;
  endfunction

  // Reference model: plain integer arithmetic on unsigned/signed values.
  function automatic exp_t model(input logic [4:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                                 input logic [NW-1:0] nv);
    exp_t   e;
    longint ua = longint'(av);
    longint ub = longint'(bv);
    longint r = 0;
    longint s = 0;
    longint cin;
    bit c = 0, v = 0, ok = 1, keep = 0, z;
`ifdef ALU_MUL_EN
    longint p = 0;
`endif
    cin = (o == OP_ADC || o == OP_SBB) ? longint'(mflags[0]) : 0;
    case (o)
      OP_AND:  r = ua & ub;
      OP_OR:   r = ua | ub;
      OP_XOR:  r = ua ^ ub;
      OP_NOT:  r = FULL - 1 - ua;
      OP_NAND: r = FULL - 1 - (ua & ub);
      OP_ADD, OP_ADC: begin
        r = ua + ub + cin;
        c = r >= FULL;
        s = sgn(ua) + sgn(ub) + cin;
        v = (s >= HALF) || (s < -HALF);
        r = r % FULL;
      end
      OP_SUB, OP_SBB: begin
        r = ua - ub - cin;
        c = r < 0;
        s = sgn(ua) - sgn(ub) - cin;
        v = (s >= HALF) || (s < -HALF);
        if (r < 0) r = r + FULL;
      end
      OP_SWAP: r = (ua % QW) * QW + ua / QW;
      OP_SHL: begin r = (ua * 2) % FULL;             c = ua >= HALF; end
      OP_ROL: begin r = (ua * 2) % FULL + cin + longint'(mflags[0]); c = ua >= HALF; end
      OP_SHR: begin r = ua / 2;                      c = (ua % 2) == 1; end
      OP_ROR: begin r = ua / 2 + (mflags[0] ? HALF : 0); c = (ua % 2) == 1; end
      OP_INC: begin r = ub + 1; c = r == FULL; r = r % FULL; end
      OP_DEC: begin c = ub == 0; r = (ub + FULL - 1) % FULL; end
      OP_CLR: r = ub & ~(longint'(1) << nv);
      OP_SET: r = ub | (longint'(1) << nv);
`ifdef ALU_MUL_EN
      OP_MUL: begin
        p   = ua * ub;
        r   = p % FULL;
        mhi = W'(p / FULL);
        c   = mhi != 0;
      end
      OP_MFHI: begin r = longint'(mhi); keep = 1; end
`endif
      default: ok = 0;
    endcase
    z = (r == 0);
`ifdef ALU_MUL_EN
    if (o == OP_MUL) z = (p == 0);
`endif
    if (ok && !keep) mflags = {v, r >= HALF, z, c};
    e.y   = ok ? W'(r) : '0;
    e.f   = mflags;
    e.e   = !ok;
    e.op  = o;
    e.acc = 0;
    e.lat = (ok && o == OP_MUL) ? W : 0;
    return e;
  endfunction

  task automatic issue(input logic [4:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic [NW-1:0] nv);
    exp_t e;
    int   g = 0;
    @(negedge clk);
    op = o; a = av; b = bv; n = nv; in_valid = 1'b1;
    #1;
    while (!in_ready && g < 200) begin
      @(negedge clk);
      #1;
      g++;
    end
    check("accept", in_ready, 1);
    if (in_ready) begin
      e = model(o, av, bv, nv);
      e.acc = cyc + 1;
      sbq.push_back(e);
      @(posedge clk);
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    while (sbq.size() != 0 && g < 500) begin
      @(negedge clk);
      g++;
    end
    check("drain_empty", sbq.size(), 0);
  endtask

  // Consumer side: randomly throttled or forced low during the stall test.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      out_ready = stall ? 1'b0 : (rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1);
    end
  end

  // Monitor: compares every presented result against the queue head; pops on handshake.
  initial begin
    exp_t h;
    bit   presented = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        presented = 1'b0;
      end else if (out_valid) begin
        if (sbq.size() == 0) begin
          check("unexpected_out_valid", out_valid, 0);
        end else begin
          h = sbq[0];
          check($sformatf("y op=%b", h.op), y, h.y);
          check($sformatf("flags op=%b", h.op), flags, h.f);
          check($sformatf("err op=%b", h.op), err, h.e);
          if (!presented) check($sformatf("latency op=%b", h.op), cyc, h.acc + h.lat);
          presented = 1'b1;
          if (out_ready) begin
            void'(sbq.pop_front());
            presented = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; op = '0; a = '0; b = '0; n = '0;
    mflags = '0;
`ifdef ALU_MUL_EN
    mhi = '0;
`endif
    repeat (3) @(negedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_y", y, 0);
    check("rst_flags", flags, 0);
    check("rst_err", err, 0);
    check("rst_in_ready", in_ready, 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1 check("in_ready_after_rst", in_ready, 1);

    // Carry chain and flag dependencies, back to back.
    issue(OP_ADD, 8'h0F, 8'hF1, '0);
    issue(OP_ADC, 8'h01, 8'h01, '0);
    issue(OP_SUB, 8'h00, 8'h01, '0);
    issue(5'b10111, 8'h55, 8'hAA, '0);
    issue(OP_ROL, 8'h96, 8'h00, '0);
    issue(OP_ROR, 8'h96, 8'h00, '0);
    for (int i = 0; i < 8; i++) issue(OP_CLR, 8'h00, 8'hFF, NW'(i));
    for (int i = 0; i < 8; i++) issue(OP_SET, 8'h00, 8'h00, NW'(i));
    issue(OP_DEC, 8'h00, 8'h00, '0);
    issue(OP_SWAP, 8'hA5, 8'h00, '0);
    issue(OP_ADD, 8'h7F, 8'h01, '0);
`ifndef ALU_MUL_EN
    issue(OP_MUL, 8'h03, 8'h04, '0);
    issue(OP_MFHI, 8'h03, 8'h04, '0);
`endif
    drain();

    // Backpressure: two requests while the consumer stalls for 5 cycles.
    stall = 1'b1;
    @(negedge clk);
    issue(OP_XOR, 8'h3C, 8'h0F, '0);
    fork
      begin
        repeat (5) begin
          @(negedge clk);
          #1 check("in_ready_stalled", in_ready, 0);
        end
        stall = 1'b0;
      end
    join_none
    issue(OP_INC, 8'h00, 8'hFF, '0);
    drain();

`ifdef ALU_MUL_EN
    issue(OP_MUL, 8'hFF, 8'hFF, '0);
    issue(OP_MFHI, 8'h00, 8'h00, '0);
    issue(OP_MUL, 8'h00, 8'h5A, '0);
    drain();

    // Reset in the middle of a multiply must drop the result and clear state.
    @(negedge clk);
    op = OP_MUL; a = 8'hC3; b = 8'h7E; in_valid = 1'b1;
    #1 check("mul_abort_accept", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mflags = '0;
    mhi = '0;
    repeat (W + 2) begin
      @(negedge clk);
      #1 check("mul_abort_no_out", out_valid, 0);
    end
    check("mul_abort_flags", flags, 0);
    check("mul_abort_in_ready", in_ready, 1);
    issue(OP_MFHI, 8'h00, 8'h00, '0);
    drain();
`endif

    // Random traffic with a throttled consumer.
    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      issue(5'($urandom_range(0, 31)), W'($urandom), W'($urandom), NW'($urandom_range(0, W - 1)));
    end
    rand_ready = 1'b0;
    drain();
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
